// File: rtl/fl_binder_rr.sv
// FrameLink N:1 binder: frame-atomic round-robin merge of INTERFACES_COUNT inputs,
// optionally stamping the source index into the SOF word.
module fl_binder_rr #(
    parameter int DATA_WIDTH       = 32,
    parameter int INTERFACES_COUNT = 4,
    parameter int INUM_INSERT      = 1,
    parameter int INUM_OFFSET      = 0,
    localparam int REM_WIDTH = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1,
    localparam int IW        = $clog2(INTERFACES_COUNT)
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic [INTERFACES_COUNT*DATA_WIDTH-1:0] RX_DATA,
    input  logic [INTERFACES_COUNT*REM_WIDTH-1:0]  RX_REM,
    input  logic [INTERFACES_COUNT-1:0]            RX_SOF_N,
    input  logic [INTERFACES_COUNT-1:0]            RX_EOF_N,
    input  logic [INTERFACES_COUNT-1:0]            RX_SOP_N,
    input  logic [INTERFACES_COUNT-1:0]            RX_EOP_N,
    input  logic [INTERFACES_COUNT-1:0]            RX_SRC_RDY_N,
    output logic [INTERFACES_COUNT-1:0]            RX_DST_RDY_N,
    output logic [DATA_WIDTH-1:0]                  TX_DATA,
    output logic [REM_WIDTH-1:0]                   TX_REM,
    output logic                                   TX_SOF_N,
    output logic                                   TX_EOF_N,
    output logic                                   TX_SOP_N,
    output logic                                   TX_EOP_N,
    output logic                                   TX_SRC_RDY_N,
    input  logic                                   TX_DST_RDY_N,
    output logic                                   dbg_locked,
    output logic [IW-1:0]                          dbg_last
);

    // Handshake: a word moves on a port in the cycle where SRC_RDY_N=0 and
    // DST_RDY_N=0 are both seen at the rising CLK edge; neither side waits on the other.

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [IW-1:0] sel, sel_next;
    logic [IW-1:0] last, last_next;

    logic [DATA_WIDTH-1:0] rx_data_a [INTERFACES_COUNT];
    logic [REM_WIDTH-1:0]  rx_rem_a  [INTERFACES_COUNT];

    for (genvar i = 0; i < INTERFACES_COUNT; i++) begin : g_unpack
        assign rx_data_a[i] = RX_DATA[i*DATA_WIDTH +: DATA_WIDTH];
        assign rx_rem_a[i]  = RX_REM[i*REM_WIDTH +: REM_WIDTH];
    end

    logic [INTERFACES_COUNT-1:0] req;
    logic [IW-1:0]               grant;
    logic                        grant_valid;
    logic [IW-1:0]               scan_idx;
    logic [IW-1:0]               active;
    logic                        active_valid;
    logic                        transfer;

    assign req = ~RX_SRC_RDY_N & ~RX_SOF_N;

    // Cyclic search starting just after the last granted input; k=N lands on last itself.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        scan_idx    = '0;
        for (int k = 1; k <= INTERFACES_COUNT; k++) begin
            scan_idx = last + IW'(k);
            if (!grant_valid && req[scan_idx]) begin
                grant       = scan_idx;
                grant_valid = 1'b1;
            end
        end
    end

    assign active       = (state == LOCKED) ? sel : grant;
    assign active_valid = !RESET && ((state == LOCKED) || grant_valid);
    assign transfer     = active_valid && !RX_SRC_RDY_N[active] && !TX_DST_RDY_N;

    always_comb begin
        TX_DATA      = rx_data_a[active];
        TX_REM       = rx_rem_a[active];
        TX_SOF_N     = 1'b1;
        TX_EOF_N     = 1'b1;
        TX_SOP_N     = 1'b1;
        TX_EOP_N     = 1'b1;
        TX_SRC_RDY_N = 1'b1;
        RX_DST_RDY_N = '1;
        if (active_valid) begin
            TX_SOF_N             = RX_SOF_N[active];
            TX_EOF_N             = RX_EOF_N[active];
            TX_SOP_N             = RX_SOP_N[active];
            TX_EOP_N             = RX_EOP_N[active];
            TX_SRC_RDY_N         = RX_SRC_RDY_N[active];
            RX_DST_RDY_N[active] = TX_DST_RDY_N;
            // The stamped index lets a downstream distributor route the frame back.
            if (INUM_INSERT != 0 && !RX_SOF_N[active]) begin
                TX_DATA[INUM_OFFSET +: IW] = active;
            end
        end
    end

    always_comb begin
        state_next = state;
        sel_next   = sel;
        last_next  = last;
        case (state)
            IDLE: begin
                if (transfer) begin
                    last_next = grant;
                    if (RX_EOF_N[grant]) begin
                        state_next = LOCKED;
                        sel_next   = grant;
                    end
                end
            end
            LOCKED: begin
                if (transfer && !RX_EOF_N[sel]) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            sel   <= '0;
            last  <= IW'(INTERFACES_COUNT - 1);
        end else begin
            state <= state_next;
            sel   <= sel_next;
            last  <= last_next;
        end
    end

    assign dbg_locked = (state == LOCKED);
    assign dbg_last   = last;

endmodule

// File: tb/tb_fl_binder_rr.sv
// Bench for fl_binder_rr: directed vector table, hand-written corner sequences and a
// randomized run checked against a frame-level round-robin reference model.
module tb_fl_binder_rr;

    localparam int DW  = 32;
    localparam int NI  = 4;
    localparam int RW  = 2;
    localparam int IW  = 2;
    localparam int OFF = 0;
    localparam int SBW = DW + RW + 4;   // {sof_n, eof_n, sop_n, eop_n, rem, data}
    localparam int NUM_FRAMES = 1000;
    localparam int MAX_CYC    = 80000;

    logic              clk = 1'b0;
    logic              rst;
    logic [NI*DW-1:0]  rx_data;
    logic [NI*RW-1:0]  rx_rem;
    logic [NI-1:0]     rx_sof_n, rx_eof_n, rx_sop_n, rx_eop_n;
    logic [NI-1:0]     rx_src_rdy_n, rx_dst_rdy_n;
    logic [DW-1:0]     tx_data;
    logic [RW-1:0]     tx_rem;
    logic              tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n;
    logic              tx_src_rdy_n, tx_dst_rdy_n;
    logic              dbg_locked;
    logic [IW-1:0]     dbg_last;

    int vec_cnt = 0;
    int err_cnt = 0;
    int salt    = 0;
    logic [SBW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    fl_binder_rr #(
        .DATA_WIDTH(DW), .INTERFACES_COUNT(NI), .INUM_INSERT(1), .INUM_OFFSET(OFF)
    ) dut (
        .CLK(clk), .RESET(rst),
        .RX_DATA(rx_data), .RX_REM(rx_rem),
        .RX_SOF_N(rx_sof_n), .RX_EOF_N(rx_eof_n), .RX_SOP_N(rx_sop_n), .RX_EOP_N(rx_eop_n),
        .RX_SRC_RDY_N(rx_src_rdy_n), .RX_DST_RDY_N(rx_dst_rdy_n),
        .TX_DATA(tx_data), .TX_REM(tx_rem),
        .TX_SOF_N(tx_sof_n), .TX_EOF_N(tx_eof_n), .TX_SOP_N(tx_sop_n), .TX_EOP_N(tx_eop_n),
        .TX_SRC_RDY_N(tx_src_rdy_n), .TX_DST_RDY_N(tx_dst_rdy_n),
        .dbg_locked(dbg_locked), .dbg_last(dbg_last)
    );

    // ---------------- helpers ----------------
    function automatic logic [DW-1:0] stamp(input logic [DW-1:0] d, input int idx);
        logic [DW-1:0] r;
        logic [IW-1:0] v;
        r = d;
        v = IW'(idx);
        r[OFF +: IW] = v;
        return r;
    endfunction

    function automatic logic [DW-1:0] row_data(input int i, input int s);
        return {8'hA5, 8'(s), 8'(i), 8'hFF};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- driver: one directed cycle ----------------
    task automatic apply_row(input string name, input logic r,
                             input logic [NI-1:0] src_n, input logic [NI-1:0] sof_n,
                             input logic [NI-1:0] eof_n, input logic dst_n,
                             input logic exp_src_n, input logic [NI-1:0] exp_rx,
                             input int exp_idx);
        logic [63:0]   got, exp;
        logic [DW-1:0] d;
        @(negedge clk);
        salt++;
        rst = r;
        for (int i = 0; i < NI; i++) begin
            rx_data[i*DW +: DW] = row_data(i, salt);
            rx_rem[i*RW +: RW]  = RW'(i);
        end
        rx_src_rdy_n = src_n;
        rx_sof_n     = sof_n;
        rx_eof_n     = eof_n;
        rx_sop_n     = sof_n;
        rx_eop_n     = eof_n;
        tx_dst_rdy_n = dst_n;
        #4;
        got = '0;
        exp = '0;
        got[4:0] = {tx_src_rdy_n, rx_dst_rdy_n};
        exp[4:0] = {exp_src_n, exp_rx};
        if (!exp_src_n) begin
            d = row_data(exp_idx, salt);
            if (!sof_n[exp_idx]) d = stamp(d, exp_idx);
            got[45:8] = {tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n, tx_rem, tx_data};
            exp[45:8] = {sof_n[exp_idx], eof_n[exp_idx], sof_n[exp_idx], eof_n[exp_idx],
                         RW'(exp_idx), d};
        end
        check(name, got, exp);
    endtask

    task automatic do_reset();
        apply_row("reset_out", 1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 4'b1111, 0);
        apply_row("reset_out", 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1111, 0);
        check("reset_state", 64'({dbg_locked, dbg_last}), 64'({1'b0, 2'd3}));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [NI-1:0] src_n;
        logic [NI-1:0] sof_n;
        logic [NI-1:0] eof_n;
        logic          dst_n;
        logic          exp_src_n;
        logic [NI-1:0] exp_rx;
        int            exp_idx;
    } row_t;

    localparam int NROWS = 18;
    row_t tbl [NROWS];

    // ---------------- random phase state ----------------
    logic [SBW-1:0] frm [NI][40];
    int             len [NI];
    int             pos [NI];
    logic [NI-1:0]  pv;
    int             gen_cnt;
    int             owner;
    int             last_g;
    int             cyc;

    task automatic gen_frame(input int i);
        int l, p, c1, c2;
        l  = $urandom_range(1, 40);
        p  = $urandom_range(1, 3);
        c1 = -1;
        c2 = -1;
        if (p >= 2 && l >= 2) c1 = $urandom_range(1, l - 1);
        if (p == 3 && l >= 2) c2 = $urandom_range(1, l - 1);
        for (int wi = 0; wi < l; wi++) begin
            frm[i][wi][DW-1:0]     = $urandom;
            frm[i][wi][DW+RW-1:DW] = RW'($urandom_range(0, 3));
            frm[i][wi][SBW-1]      = (wi != 0);
            frm[i][wi][SBW-2]      = (wi != l - 1);
            frm[i][wi][SBW-3]      = !(wi == 0 || wi == c1 || wi == c2);
            frm[i][wi][SBW-4]      = !(wi == l - 1 || wi + 1 == c1 || wi + 1 == c2);
        end
        len[i] = l;
        pos[i] = 0;
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < NI; i++) if (pos[i] != len[i]) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [NI-1:0]  erx;
        logic [SBW-1:0] w, e;
        logic           esrc;
        int             act, j;

        rst          = 1'b1;
        rx_data      = '0;
        rx_rem       = '0;
        rx_src_rdy_n = '1;
        rx_sof_n     = '1;
        rx_eof_n     = '1;
        rx_sop_n     = '1;
        rx_eop_n     = '1;
        tx_dst_rdy_n = 1'b0;

        // Four 3-word frames back-to-back in input order, then pointer-wrap and idle rows.
        for (int r = 0; r < 12; r++) begin
            int a, wd;
            a  = r / 3;
            wd = r % 3;
            for (int i = 0; i < NI; i++) begin
                if (i < a) begin
                    tbl[r].src_n[i] = 1'b1; tbl[r].sof_n[i] = 1'b1; tbl[r].eof_n[i] = 1'b1;
                end else if (i > a) begin
                    tbl[r].src_n[i] = 1'b0; tbl[r].sof_n[i] = 1'b0; tbl[r].eof_n[i] = 1'b1;
                end else begin
                    tbl[r].src_n[i] = 1'b0; tbl[r].sof_n[i] = (wd != 0); tbl[r].eof_n[i] = (wd != 2);
                end
            end
            tbl[r].dst_n     = 1'b0;
            tbl[r].exp_src_n = 1'b0;
            tbl[r].exp_rx    = ~(NI'(1) << a);
            tbl[r].exp_idx   = a;
        end
        tbl[12] = '{4'b1011, 4'b1011, 4'b1011, 1'b0, 1'b0, 4'b1011, 2};
        tbl[13] = '{4'b0101, 4'b0101, 4'b0101, 1'b1, 1'b0, 4'b1111, 3};
        tbl[14] = '{4'b0101, 4'b0101, 4'b0101, 1'b0, 1'b0, 4'b0111, 3};
        tbl[15] = '{4'b1101, 4'b1101, 4'b1101, 1'b0, 1'b0, 4'b1101, 1};
        tbl[16] = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1111, 0};
        tbl[17] = '{4'b1110, 4'b1111, 4'b1111, 1'b0, 1'b1, 4'b1111, 0};

        do_reset();
        for (int r = 0; r < NROWS; r++) begin
            apply_row($sformatf("tbl%0d", r), 1'b0, tbl[r].src_n, tbl[r].sof_n, tbl[r].eof_n,
                      tbl[r].dst_n, tbl[r].exp_src_n, tbl[r].exp_rx, tbl[r].exp_idx);
        end

        // Source gap inside input 1's frame while input 0 keeps requesting.
        do_reset();
        apply_row("gap_sof", 1'b0, 4'b1101, 4'b1101, 4'b1111, 1'b0, 1'b0, 4'b1101, 1);
        for (int c = 0; c < 5; c++)
            apply_row("gap_hold", 1'b0, 4'b1110, 4'b1110, 4'b1111, 1'b0, 1'b1, 4'b1101, 1);
        apply_row("gap_eof", 1'b0, 4'b1100, 4'b1110, 4'b1101, 1'b0, 1'b0, 4'b1101, 1);
        apply_row("gap_next", 1'b0, 4'b1110, 4'b1110, 4'b1110, 1'b0, 1'b0, 4'b1110, 0);

        // Continuous single-word frames: grant rotates every cycle, never locks.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            erx = ~(NI'(1) << (c % NI));
            apply_row("single", 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, erx, c % NI);
            @(posedge clk);
            #1;
            check("single_unlocked", 64'(dbg_locked), 64'(0));
        end

        // Reset pulse in the middle of input 2's frame.
        do_reset();
        apply_row("mid_sof", 1'b0, 4'b1011, 4'b1011, 4'b1111, 1'b0, 1'b0, 4'b1011, 2);
        apply_row("mid_word", 1'b0, 4'b1010, 4'b1110, 4'b1111, 1'b0, 1'b0, 4'b1011, 2);
        apply_row("mid_rst", 1'b1, 4'b1010, 4'b1110, 4'b1111, 1'b0, 1'b1, 4'b1111, 0);
        apply_row("mid_after", 1'b0, 4'b1010, 4'b1010, 4'b1111, 1'b0, 1'b0, 4'b1110, 0);

        // Randomized frames against the frame-level round-robin model.
        do_reset();
        for (int i = 0; i < NI; i++) begin
            len[i] = 0;
            pos[i] = 0;
        end
        gen_cnt = 0;
        owner   = -1;
        last_g  = NI - 1;
        cyc     = 0;
        while (!(gen_cnt == NUM_FRAMES && all_idle()) && cyc < MAX_CYC) begin
            @(negedge clk);
            cyc++;
            rst = 1'b0;
            for (int i = 0; i < NI; i++)
                if (pos[i] == len[i] && gen_cnt < NUM_FRAMES && $urandom_range(0, 3) == 0) begin
                    gen_frame(i);
                    gen_cnt++;
                end
            for (int i = 0; i < NI; i++) begin
                pv[i] = (pos[i] < len[i]) && ($urandom_range(0, 15) != 0);
                if (pos[i] < len[i]) w = frm[i][pos[i]];
                else                 w = {4'($urandom), RW'($urandom), DW'($urandom)};
                rx_data[i*DW +: DW] = w[DW-1:0];
                rx_rem[i*RW +: RW]  = w[DW+RW-1:DW];
                rx_sof_n[i]         = w[SBW-1];
                rx_eof_n[i]         = w[SBW-2];
                rx_sop_n[i]         = w[SBW-3];
                rx_eop_n[i]         = w[SBW-4];
                rx_src_rdy_n[i]     = !pv[i];
            end
            tx_dst_rdy_n = 1'($urandom_range(0, 1));
            #4;
            act = owner;
            if (act < 0) begin
                for (int k = 1; k <= NI; k++) begin
                    j = (last_g + k) % NI;
                    if (act < 0 && pv[j] && !frm[j][pos[j]][SBW-1]) act = j;
                end
            end
            esrc = 1'b1;
            erx  = '1;
            if (act >= 0) begin
                esrc     = !pv[act];
                erx[act] = tx_dst_rdy_n;
            end
            check("rand_hs", 64'({tx_src_rdy_n, rx_dst_rdy_n}), 64'({esrc, erx}));
            if (act >= 0 && pv[act] && !tx_dst_rdy_n) begin
                w = frm[act][pos[act]];
                if (!w[SBW-1]) w[DW-1:0] = stamp(w[DW-1:0], act);
                exp_q.push_back(w);
                pos[act]++;
                if (owner < 0) begin
                    last_g = act;
                    if (w[SBW-2]) owner = act;
                end else if (!w[SBW-2]) begin
                    owner = -1;
                end
            end
            if (!tx_src_rdy_n && !tx_dst_rdy_n) begin
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL rand_word: got unexpected word %h, required none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rand_word",
                          64'({tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n, tx_rem, tx_data}), 64'(e));
                end
            end
        end
        if (cyc >= MAX_CYC) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL rand_timeout: got %0d frames pending, required 0", NUM_FRAMES - gen_cnt);
        end
        check("sb_empty", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/fl_binder_rr.md
Name: fl_binder_rr

Overview:
- Merges INTERFACES_COUNT FrameLink input streams into one FrameLink output. This is the complement of the FrameLink distributor.
- Arbitration is round-robin and frame-atomic. Once a frame starts, it is passed whole with no interleaving.
- Optionally stamps the source input index into the first word of each frame, at the same header offset the distributor reads. A binder-to-distributor chain therefore round-trips the routing information.

Parameters:
- DATA_WIDTH, 32: FrameLink data width in bits (8..128, power of 2). REM_WIDTH = log2(DATA_WIDTH/8).
- INTERFACES_COUNT, 4: number of input interfaces (2..16, power of 2). IW = log2(INTERFACES_COUNT).
- INUM_INSERT, 1: 1 = overwrite index bits in the SOF word; 0 = pass data unmodified.
- INUM_OFFSET, 0: bit position of the index field in the SOF word. Requires INUM_OFFSET+IW <= DATA_WIDTH.

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous reset, active-high
- RX_DATA  in  INTERFACES_COUNT*DATA_WIDTH  input data; interface i occupies slice [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- RX_REM  in  INTERFACES_COUNT*REM_WIDTH  input rem, sliced the same way
- RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N  in  INTERFACES_COUNT  per-input frame/part delimiters, active-low
- RX_SRC_RDY_N  in  INTERFACES_COUNT  per-input source ready, active-low
- RX_DST_RDY_N  out  INTERFACES_COUNT  per-input destination ready, active-low
- TX_DATA  out  DATA_WIDTH  output data
- TX_REM  out  REM_WIDTH  output rem
- TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N  out  1  output delimiters
- TX_SRC_RDY_N  out  1  output source ready
- TX_DST_RDY_N  in  1  output destination ready

Behaviour:
- Transfer rule: a word moves on a port when SRC_RDY_N=0 and DST_RDY_N=0 in the same cycle, sampled on the rising CLK edge.
- State registers:
  - fsm: IDLE or LOCKED.
  - sel (IW bits): the locked input.
  - last (IW bits): the most recently granted input.
- Reset values: fsm=IDLE, sel=0, last=INTERFACES_COUNT-1, so input 0 has first priority.
- Outputs while RESET=1: TX_SRC_RDY_N=1, all RX_DST_RDY_N=1, TX_SOF_N/EOF_N/SOP_N/EOP_N=1. TX_DATA and TX_REM are don't-care.
- Request: input i requests when RX_SRC_RDY_N(i)=0 and RX_SOF_N(i)=0.
- IDLE:
  - Grant g = first requesting input in cyclic order last+1, last+2, ... , last.
  - The grant is combinational, so a frame's first word passes in the same cycle with zero latency.
  - If no input requests: TX_SRC_RDY_N=1 and all RX_DST_RDY_N=1.
  - A non-SOF word presented in IDLE is never granted. This is a protocol violation; it is stalled and not flagged.
- LOCKED: the output mux selects sel. Only input sel sees its DST_RDY_N; every other input gets RX_DST_RDY_N=1.
- Datapath:
  - TX_* = RX_*(active input), combinational.
  - RX_DST_RDY_N(active) = TX_DST_RDY_N.
  - Latency is 0 cycles.
- Index stamping: when INUM_INSERT=1 and the word has TX_SOF_N=0, TX_DATA[INUM_OFFSET+IW-1:INUM_OFFSET] = active index. All other bits and all non-SOF words pass unchanged.
- Transitions:
  - IDLE -> LOCKED: on a transferred SOF word with EOF_N=1; sel<=g, last<=g.
  - IDLE -> IDLE: on a transferred SOF word with EOF_N=0 (single-word frame); last<=g.
  - LOCKED -> IDLE: on a transferred word with EOF_N=0.
  - TX_DST_RDY_N=1 holds the state and the grant. The IDLE grant may change while stalled, since no word has moved yet.
- Fairness: after a frame from input k, all other requesting inputs are served before k again. Worst-case wait is INTERFACES_COUNT-1 frames.
- Parts (SOP_N/EOP_N) are passed unchanged and do not affect arbitration.
- Source gaps: RX_SRC_RDY_N(sel)=1 mid-frame keeps the lock and gives TX_SRC_RDY_N=1. No other input is granted.
- Reset mid-frame: the lock is dropped immediately (asynchronous). The output frame is truncated with no EOF emitted. The bench must discard it.

Test Plan:
- Inputs 0..3 each hold a 3-word frame after reset with TX_DST_RDY_N=0 -> output frames from inputs 0,1,2,3 in order, back-to-back with no idle cycle between frames, 12 words total. With INUM_OFFSET=0, SOF words carry DATA[1:0]=0,1,2,3.
- After input 2 finishes a frame, inputs 1 and 3 request -> input 3 is granted first (pointer wrap), then input 1.
- Input 1 is mid-frame with SRC_RDY_N=1 for 5 cycles while input 0 requests -> TX_SRC_RDY_N=1 for those 5 cycles, RX_DST_RDY_N(0)=1 throughout, frame 1 completes before input 0 is granted.
- Single-word frames (SOF=EOF=0) on all inputs continuously -> one word per cycle, grant rotates every cycle, fsm never enters LOCKED.
- Random TX_DST_RDY_N (50%) with 1000 random frames, 1-40 words and 1-3 parts each, on 4 inputs -> per-input frame contents and part boundaries are bit-exact apart from the stamped field, and no interleaving appears inside any frame.
- RESET asserted for 1 cycle mid-frame on input 2 -> same-cycle TX_SRC_RDY_N=1 and RX_DST_RDY_N="1111". After release, the first grant goes to input 0 if it requests.
